// File: rtl/interrupt_ctrl.sv
// Interrupt controller: rising-edge capture into IF (FF0F), masking by IE (FFFF),
// fixed-priority request/vector to the CPU and flag clear on acknowledge.
module interrupt_ctrl (
  input  logic        clk,
  input  logic        nreset2,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic        ffxx,
  input  logic        int_vblank,
  input  logic        int_stat,
  input  logic        int_timer,
  input  logic        int_serial,
  input  logic        int_joypad,
  input  logic        cpu_ack,
  output logic        cpu_irq,
  output logic [7:0]  cpu_vector
);

  logic [4:0] r_prev;
  logic [4:0] r_if;
  logic [7:0] r_ie;

  logic [4:0] w_src;
  logic [4:0] w_rise;
  logic [4:0] w_pend;
  logic [4:0] w_ack_sel;
  logic [4:0] w_if_next;
  logic       w_sel_if;
  logic       w_sel_ie;
  logic       w_drive;
  logic [7:0] w_rdata;
  logic       w_unused_ahi;

  // Decode relies on ffxx for the high byte; a[15:8] is intentionally not used.
  assign w_unused_ahi = ^a[15:8];

  assign w_src    = {int_joypad, int_serial, int_timer, int_stat, int_vblank};
  assign w_rise   = w_src & ~r_prev;
  assign w_pend   = r_if & r_ie[4:0];
  // Isolates the lowest set bit of pend: the flag the CPU is acknowledging.
  assign w_ack_sel = w_pend & (~w_pend + 5'd1);

  assign w_sel_if = ffxx && (a[7:0] == 8'h0F);
  assign w_sel_ie = ffxx && (a[7:0] == 8'hFF);

  // Precedence: hold < ack clear < CPU write < rising edge.
  always_comb begin
    w_if_next = r_if;
    if (cpu_ack) begin
      w_if_next = r_if & ~w_ack_sel;
    end
    if (cpu_wr && w_sel_if) begin
      w_if_next = d[4:0];
    end
    w_if_next = w_if_next | w_rise;
  end

  always_ff @(posedge clk or negedge nreset2) begin
    if (!nreset2) begin
      r_prev <= 5'd0;
      r_if   <= 5'd0;
      r_ie   <= 8'h00;
    end else begin
      r_prev <= w_src;
      r_if   <= w_if_next;
      if (cpu_wr && w_sel_ie) begin
        r_ie <= d;
      end
    end
  end

  assign cpu_irq = |w_pend;

  always_comb begin
    cpu_vector = 8'h00;
    if (w_pend[4]) cpu_vector = 8'h60;
    if (w_pend[3]) cpu_vector = 8'h58;
    if (w_pend[2]) cpu_vector = 8'h50;
    if (w_pend[1]) cpu_vector = 8'h48;
    if (w_pend[0]) cpu_vector = 8'h40;
  end

  assign w_rdata = w_sel_if ? {3'b111, r_if} : r_ie;
  // Bus released during reset even if a read is in progress.
  assign w_drive = nreset2 && cpu_rd && (w_sel_if || w_sel_ie);
  assign d       = w_drive ? w_rdata : 8'hzz;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed scenarios plus random traffic, checked
// against a flag/enable model built from the edge, priority and ack rules.
module tb_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        nreset2;
  logic [15:0] a;
  wire  [7:0]  d;
  logic [7:0]  tb_d;
  logic        tb_den;
  logic        cpu_wr, cpu_rd, ffxx, cpu_ack;
  logic [4:0]  src;
  logic        cpu_irq;
  logic [7:0]  cpu_vector;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] m_if, m_prev;
  logic [7:0] m_ie;
  logic [7:0] last_d;

  always #5 clk = ~clk;
  assign d = tb_den ? tb_d : 8'hzz;

  interrupt_ctrl dut (
    .clk        (clk),
    .nreset2    (nreset2),
    .a          (a),
    .d          (d),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .ffxx       (ffxx),
    .int_vblank (src[0]),
    .int_stat   (src[1]),
    .int_timer  (src[2]),
    .int_serial (src[3]),
    .int_joypad (src[4]),
    .cpu_ack    (cpu_ack),
    .cpu_irq    (cpu_irq),
    .cpu_vector (cpu_vector)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_vector();
    logic [4:0] pend;
    logic [7:0] v;
    logic       found;
    pend  = m_if & m_ie[4:0];
    v     = 8'h00;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!found && pend[i]) begin
        v     = 8'h40 + 8'(8 * i);
        found = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic m_reset();
    m_if   = 5'd0;
    m_ie   = 8'h00;
    m_prev = 5'd0;
  endtask

  // One bus cycle: apply inputs, check pre-edge outputs, then advance model at the edge.
  task automatic cycle(input logic [4:0] s, input logic wr, input logic rd,
                       input logic [7:0] alo, input logic [7:0] wdata, input logic ack);
    logic       sel_if, sel_ie, dut_drive;
    logic [4:0] rise, pend, nif;
    logic       done;
    a       = {8'hFF, alo};
    src     = s;
    cpu_wr  = wr;
    cpu_rd  = rd;
    cpu_ack = ack;
    sel_if    = ffxx && (alo == 8'h0F);
    sel_ie    = ffxx && (alo == 8'hFF);
    dut_drive = rd && (sel_if || sel_ie);
    tb_den    = !dut_drive;
    tb_d      = wr ? wdata : 8'h5A;
    #3;
    check("irq", {7'd0, cpu_irq}, {7'd0, |(m_if & m_ie[4:0])});
    check("vector", cpu_vector, m_vector());
    last_d = d;
    if (dut_drive) check("read", d, sel_if ? {3'b111, m_if} : m_ie);
    else           check("bus_release", d, tb_d);
    @(posedge clk);
    rise = s & ~m_prev;
    pend = m_if & m_ie[4:0];
    nif  = m_if;
    done = 1'b0;
    if (ack) begin
      for (int i = 0; i < 5; i++) begin
        if (!done && pend[i]) begin
          nif[i] = 1'b0;
          done   = 1'b1;
        end
      end
    end
    if (wr && sel_if) nif = wdata[4:0];
    nif = nif | rise;
    if (wr && sel_ie) m_ie = wdata;
    m_if   = nif;
    m_prev = s;
    #1;
  endtask

  initial begin
    logic [4:0] rs;
    logic       rwr, rrd, rack;
    logic [7:0] ralo, rdat;

    nreset2 = 1'b0;
    a = 16'h0000; src = 5'd0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_ack = 1'b0;
    ffxx = 1'b1; tb_den = 1'b1; tb_d = 8'h00;
    m_reset();
    #12 nreset2 = 1'b1;
    @(posedge clk); #1;

    // Level held high sets IF once; clearing while held does not re-set.
    cycle(5'd0, 1'b1, 1'b0, 8'hFF, 8'h08, 1'b0);
    for (int i = 0; i < 10; i++) cycle(5'b01000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(5'b01000, 1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
    check("hold_if", last_d, 8'hE8);
    cycle(5'b01000, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0);
    cycle(5'b01000, 1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
    check("clear_held_if", last_d, 8'hE0);
    check("clear_held_irq", {7'd0, cpu_irq}, 8'h00);
    cycle(5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Priority and acknowledge.
    cycle(5'd0, 1'b1, 1'b0, 8'hFF, 8'h1F, 1'b0);
    cycle(5'b10100, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("prio_vec", cpu_vector, 8'h50);
    cycle(5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    check("ack1_vec", cpu_vector, 8'h60);
    cycle(5'd0, 1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
    check("ack1_if", last_d, 8'hF0);
    cycle(5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    check("ack2_vec", cpu_vector, 8'h00);
    check("ack2_irq", {7'd0, cpu_irq}, 8'h00);

    // Ack colliding with a new rise on the same bit.
    cycle(5'b01000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cycle(5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("coll_vec_pre", cpu_vector, 8'h58);
    cycle(5'b01000, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    check("coll_irq", {7'd0, cpu_irq}, 8'h01);
    check("coll_vec", cpu_vector, 8'h58);
    cycle(5'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

    // Masking by IE.
    cycle(5'd0, 1'b1, 1'b0, 8'hFF, 8'hE0, 1'b0);
    cycle(5'd0, 1'b1, 1'b0, 8'h0F, 8'h1F, 1'b0);
    check("mask_irq", {7'd0, cpu_irq}, 8'h00);
    cycle(5'd0, 1'b1, 1'b0, 8'hFF, 8'h01, 1'b0);
    check("enable_irq", {7'd0, cpu_irq}, 8'h01);
    check("enable_vec", cpu_vector, 8'h40);
    cycle(5'd0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    check("ie_read", last_d, 8'h01);
    cycle(5'd0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
    check("no_rd_release", last_d, 8'h5A);

    // Write of 0 racing a vblank rise.
    cycle(5'd0, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0);
    cycle(5'b00001, 1'b1, 1'b0, 8'h0F, 8'h00, 1'b0);
    cycle(5'b00001, 1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
    check("race_if", last_d, 8'hE1);

    // Async reset mid-write; stat held high through release.
    a = 16'hFF0F; cpu_wr = 1'b1; cpu_rd = 1'b0; cpu_ack = 1'b0;
    tb_den = 1'b1; tb_d = 8'h1F; src = 5'b00010;
    #2 nreset2 = 1'b0;
    #1;
    check("rst_irq", {7'd0, cpu_irq}, 8'h00);
    check("rst_vec", cpu_vector, 8'h00);
    @(posedge clk); #1;
    check("rst_hold_irq", {7'd0, cpu_irq}, 8'h00);
    #2 nreset2 = 1'b1;
    m_reset();
    cycle(5'b00010, 1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
    check("rst_if", last_d, 8'hE0);
    cycle(5'b00010, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    check("rst_ie", last_d, 8'h00);
    cycle(5'b00010, 1'b0, 1'b1, 8'h0F, 8'h00, 1'b0);
    check("rst_release_rise", last_d, 8'hE2);

    // Random traffic against the model.
    rs = 5'b00010;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(3) == 0) rs[b] = ~rs[b];
      rwr  = ($urandom_range(7) == 0);
      rrd  = !rwr && ($urandom_range(3) == 0);
      rack = ($urandom_range(5) == 0);
      case ($urandom_range(2))
        0:       ralo = 8'h0F;
        1:       ralo = 8'hFF;
        default: ralo = 8'($urandom);
      endcase
      ffxx = ($urandom_range(7) != 0);
      rdat = 8'($urandom);
      cycle(rs, rwr, rrd, ralo, rdat, rack);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
